pipelined_processor: RTL and testbench



---
 rtl/proc_pkg.sv | 38 +++
 rtl/pipelined_processor_if.sv | 17 +
 rtl/proc_alu.sv | 24 ++
 rtl/pipelined_processor.sv | 117 +++++++++++
 tb/tb_pipelined_processor.sv | 144 ++++++++++++++
 5 files changed

// File: rtl/proc_pkg.sv
// Shared constants, instruction field positions and the EX/WB pipeline
// register type for the 3-stage pipelined processor.
package proc_pkg;

    localparam int DATA_W     = 16;
    localparam int IMEM_DEPTH = 16;
    localparam int NREGS      = 8;
    localparam int PC_W       = $clog2(IMEM_DEPTH);
    localparam int REG_W      = $clog2(NREGS);

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_AND  = 4'd3;
    localparam logic [3:0] OP_OR   = 4'd4;
    localparam logic [3:0] OP_XOR  = 4'd5;
    localparam logic [3:0] OP_ADDI = 4'd6;
    localparam logic [3:0] OP_SLL  = 4'd7;

    localparam int OPC_HI = 15;
    localparam int OPC_LO = 12;
    localparam int RD_HI  = 11;
    localparam int RD_LO  = 9;
    localparam int RS_HI  = 8;
    localparam int RS_LO  = 6;
    localparam int RT_HI  = 5;
    localparam int RT_LO  = 3;
    localparam int IMM_HI = 5;
    localparam int IMM_LO = 0;
    localparam int IMM_W  = IMM_HI - IMM_LO + 1;

    typedef struct packed {
        logic              we;
        logic [REG_W-1:0]  rd;
        logic [DATA_W-1:0] result;
    } exwb_t;

endpackage

// File: rtl/pipelined_processor_if.sv
// Connection between the EX stage (master) and the ALU (slave).
interface pipelined_processor_if;
    import proc_pkg::*;

    logic [3:0]        opcode;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] simm;
    logic [DATA_W-1:0] result;
    logic              we;

    modport master (output opcode, output a, output b, output simm,
                    input result, input we);
    modport slave  (input opcode, input a, input b, input simm,
                    output result, output we);

endinterface

// File: rtl/proc_alu.sv
// Combinational ALU; unknown opcodes behave as NOP (no writeback).
module proc_alu
    import proc_pkg::*;
(
    pipelined_processor_if.slave alu
);

    // Opcode decode and result selection
    always_comb begin
        alu.result = '0;
        alu.we     = 1'b0;
        case (alu.opcode)
            OP_ADD:  begin alu.result = alu.a + alu.b;      alu.we = 1'b1; end
            OP_SUB:  begin alu.result = alu.a - alu.b;      alu.we = 1'b1; end
            OP_AND:  begin alu.result = alu.a & alu.b;      alu.we = 1'b1; end
            OP_OR:   begin alu.result = alu.a | alu.b;      alu.we = 1'b1; end
            OP_XOR:  begin alu.result = alu.a ^ alu.b;      alu.we = 1'b1; end
            OP_ADDI: begin alu.result = alu.a + alu.simm;   alu.we = 1'b1; end
            OP_SLL:  begin alu.result = alu.a << alu.b[3:0]; alu.we = 1'b1; end
            default: begin alu.result = '0;                 alu.we = 1'b0; end
        endcase
    end

endmodule

// File: rtl/pipelined_processor.sv
// 3-stage (IF, EX, WB) 16-bit processor with internal ROM and 8-entry
// register file. ROM_SEL=1 selects a small r0-discard test program.
// Optional macro PROC_TRACE_EN prints each committed writeback.
module pipelined_processor
    import proc_pkg::*;
#(
    parameter int ROM_SEL = 0
)
(
    input logic clk,
    input logic reset
);

    logic [PC_W-1:0]   r_pc;
    logic [DATA_W-1:0] r_ifex;
    exwb_t             r_exwb;
    logic [DATA_W-1:0] r_regs [NREGS];

    logic [DATA_W-1:0] w_rom_data;
    logic [3:0]        w_opcode;
    logic [REG_W-1:0]  w_rd;
    logic [REG_W-1:0]  w_rs;
    logic [REG_W-1:0]  w_rt;
    logic [DATA_W-1:0] w_rs_val;
    logic [DATA_W-1:0] w_rt_val;
    logic              w_fwd_rs;
    logic              w_fwd_rt;

    pipelined_processor_if u_alu_if ();

    proc_alu u_alu (.alu(u_alu_if.slave));

    // Fixed instruction ROM, combinational read
    always_comb begin
        w_rom_data = '0;
        if (ROM_SEL == 1) begin
            case (r_pc)
                4'd0:    w_rom_data = 16'h1050; // ADD r0,r1,r2
                4'd1:    w_rom_data = 16'h1600; // ADD r3,r0,r0
                default: w_rom_data = 16'h0000;
            endcase
        end else begin
            case (r_pc)
                4'd0:    w_rom_data = 16'h1298; // ADD  r1,r2,r3
                4'd1:    w_rom_data = 16'h2850; // SUB  r4,r1,r2
                4'd2:    w_rom_data = 16'h3B38; // AND  r5,r4,r7
                4'd3:    w_rom_data = 16'h4D48; // OR   r6,r5,r1
                4'd4:    w_rom_data = 16'h6FBF; // ADDI r7,r6,-1
                4'd5:    w_rom_data = 16'h55D8; // XOR  r2,r7,r3
                default: w_rom_data = 16'h0000;
            endcase
        end
    end

    // IF stage: PC saturates so the trailing NOPs repeat
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc   <= '0;
            r_ifex <= '0;
        end else begin
            r_ifex <= w_rom_data;
            if (r_pc != PC_W'(IMEM_DEPTH - 1)) begin
                r_pc <= r_pc + 1'b1;
            end
        end
    end

    // EX decode with single-path forwarding from EX/WB; r0 never forwards
    always_comb begin
        w_opcode = r_ifex[OPC_HI:OPC_LO];
        w_rd     = r_ifex[RD_HI:RD_LO];
        w_rs     = r_ifex[RS_HI:RS_LO];
        w_rt     = r_ifex[RT_HI:RT_LO];
        w_fwd_rs = r_exwb.we && (r_exwb.rd != '0) && (r_exwb.rd == w_rs);
        w_fwd_rt = r_exwb.we && (r_exwb.rd != '0) && (r_exwb.rd == w_rt);
        w_rs_val = w_fwd_rs ? r_exwb.result : r_regs[w_rs];
        w_rt_val = w_fwd_rt ? r_exwb.result : r_regs[w_rt];
        u_alu_if.opcode = w_opcode;
        u_alu_if.a      = w_rs_val;
        u_alu_if.b      = w_rt_val;
        u_alu_if.simm   = {{(DATA_W - IMM_W){r_ifex[IMM_HI]}}, r_ifex[IMM_HI:IMM_LO]};
    end

    // EX/WB pipeline register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_exwb <= '0;
        end else begin
            r_exwb.we     <= u_alu_if.we;
            r_exwb.rd     <= w_rd;
            r_exwb.result <= u_alu_if.result;
        end
    end

    // WB stage: register file, r0 stays hard-wired to zero
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= DATA_W'(i);
            end
        end else if (r_exwb.we && (r_exwb.rd != '0)) begin
            r_regs[r_exwb.rd] <= r_exwb.result;
        end
    end

`ifdef PROC_TRACE_EN
    // Simulation trace of each committed writeback
    always @(posedge clk) begin
        if (reset && r_exwb.we && (r_exwb.rd != '0)) begin
            $display("WB r%0d = %h", r_exwb.rd, r_exwb.result);
        end
    end
`else
    // No trace logic in this build
`endif

endmodule

// File: tb/tb_pipelined_processor.sv
module tb_pipelined_processor;
    import proc_pkg::*;

    typedef struct {
        int                edge_no;
        int                rd;
        logic [DATA_W-1:0] val;
    } sb_t;

    logic clk;
    logic reset;
    int   ntests;
    int   nfail;
    int   edge_cnt;
    sb_t  sb_q [$];
    logic [DATA_W-1:0] model [NREGS];

    pipelined_processor #(.ROM_SEL(0)) dut   (.clk(clk), .reset(reset));
    pipelined_processor #(.ROM_SEL(1)) dut_v (.clk(clk), .reset(reset));

    pipelined_processor_if u_if ();
    proc_alu u_alu (.alu(u_if.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cmp(input string tag, input logic [DATA_W-1:0] obs,
                       input logic [DATA_W-1:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NREGS; i++) model[i] = DATA_W'(i);
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < NREGS; i++) begin
            cmp($sformatf("%s_e%0d_r%0d", tag, edge_cnt, i), dut.r_regs[i], model[i]);
        end
    endtask

    task automatic push_program();
        sb_q.push_back('{3, 1, 16'h0005});
        sb_q.push_back('{4, 4, 16'h0003});
        sb_q.push_back('{5, 5, 16'h0003});
        sb_q.push_back('{6, 6, 16'h0007});
        sb_q.push_back('{7, 7, 16'h0006});
        sb_q.push_back('{8, 2, 16'h0005});
    endtask

    task automatic run_edges(input int n, input string tag);
        sb_t e;
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            edge_cnt++;
            while (sb_q.size() > 0 && sb_q[0].edge_no == edge_cnt) begin
                e = sb_q.pop_front();
                model[e.rd] = e.val;
            end
            check_regs(tag);
        end
    endtask

    task automatic alu_check(input string tag, input logic [3:0] op,
                             input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                             input logic [DATA_W-1:0] simm,
                             input logic [DATA_W-1:0] exp_res, input logic exp_we);
        u_if.opcode = op;
        u_if.a      = a;
        u_if.b      = b;
        u_if.simm   = simm;
        #1;
        cmp({tag, "_we"}, DATA_W'(u_if.we), DATA_W'(exp_we));
        if (exp_we) cmp({tag, "_res"}, u_if.result, exp_res);
    endtask

    initial begin
        ntests   = 0;
        nfail    = 0;
        edge_cnt = 0;

        // Standalone ALU checks
        alu_check("alu_add_wrap", OP_ADD,  16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 1'b1);
        alu_check("alu_sub_neg",  OP_SUB,  16'h0002, 16'h0005, 16'h0000, 16'hFFFD, 1'b1);
        alu_check("alu_sll15",    OP_SLL,  16'h0001, 16'h001F, 16'h0000, 16'h8000, 1'b1);
        alu_check("alu_addi_neg", OP_ADDI, 16'h0003, 16'h1234, 16'hFFFF, 16'h0002, 1'b1);
        alu_check("alu_xor",      OP_XOR,  16'hA5A5, 16'h0FF0, 16'h0000, 16'hAA55, 1'b1);
        alu_check("alu_op9_nop",  4'd9,    16'h0001, 16'h0001, 16'h0000, 16'h0000, 1'b0);
        alu_check("alu_nop",      OP_NOP,  16'h0001, 16'h0001, 16'h0000, 16'h0000, 1'b0);

        // Scenario 1: reset, run program edge by edge
        reset = 1'b0;
        model_reset();
        #1;
        check_regs("reset");
        cmp("reset_pc", DATA_W'(dut.r_pc), 16'h0000);
        reset = 1'b1;
        edge_cnt = 0;
        push_program();
        run_edges(8, "run1");
        cmp("sb_empty1", DATA_W'(sb_q.size()), 16'h0000);

        // Scenario 2: reset mid-program after edge 5
        reset = 1'b0;
        #1;
        model_reset();
        reset = 1'b1;
        edge_cnt = 0;
        push_program();
        run_edges(5, "mid");
        reset = 1'b0;
        #2;
        model_reset();
        sb_q.delete();
        check_regs("midrst");
        cmp("midrst_pc", DATA_W'(dut.r_pc), 16'h0000);
        cmp("midrst_exwb_we", DATA_W'(dut.r_exwb.we), 16'h0000);
        reset = 1'b1;
        edge_cnt = 0;
        push_program();
        run_edges(8, "run2");
        cmp("sb_empty2", DATA_W'(sb_q.size()), 16'h0000);

        // Scenario 3: long run, PC saturates, no further changes
        run_edges(20, "sat");
        cmp("pc_sat", DATA_W'(dut.r_pc), 16'h000F);

        // Scenario 4: r0 write discarded, no forwarding from r0
        cmp("var_r0", dut_v.r_regs[0], 16'h0000);
        cmp("var_r3", dut_v.r_regs[3], 16'h0000);
        cmp("var_r1", dut_v.r_regs[1], 16'h0001);
        cmp("var_r2", dut_v.r_regs[2], 16'h0002);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
